// File: rtl/led_pattern_pwm.sv
// Multi-channel LED pattern generator (alternate/chase/bounce/breathe) with PWM brightness.
// Optional build macro LED_GAMMA_EN squares the duty for perceptual dimming.
module led_pattern_pwm #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int NUM_LEDS = 8,
    parameter int PWM_BITS = 8,
    parameter int STEP_MS  = 250
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] leds,
    output logic                step_pulse
);

    localparam int STEP_CYCLES = CLK_FREQ / 1000 * STEP_MS;
    localparam int PRE_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam logic [NUM_LEDS-1:0] ONE_HOT  = NUM_LEDS'(1);

    typedef enum logic [1:0] {
        MODE_ALT     = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_BOUNCE  = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    function automatic logic [NUM_LEDS-1:0] alt_mask();
        logic [NUM_LEDS-1:0] m;
        for (int i = 0; i < NUM_LEDS; i++) m[i] = (i % 2 == 0);
        return m;
    endfunction

    localparam logic [NUM_LEDS-1:0] ALT_INIT = alt_mask();

    mode_t               mode_q, mode_q_nxt;
    dir_t                dir, dir_nxt;
    logic [NUM_LEDS-1:0] mask, mask_nxt;
    logic [PWM_BITS-1:0] duty, duty_nxt;
    logic [PWM_BITS-1:0] pwm_cnt, pwm_cnt_nxt;
    logic [PRE_W-1:0]    prescaler, prescaler_nxt;
    logic [NUM_LEDS-1:0] leds_nxt;
    logic                step_nxt;
    logic [PWM_BITS-1:0] duty_eff;

`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] duty_sq;
    assign duty_sq  = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
    assign duty_eff = PWM_BITS'(duty_sq >> PWM_BITS);
`else
    assign duty_eff = duty;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= MODE_ALT;
            dir        <= DIR_UP;
            mask       <= ALT_INIT;
            duty       <= DUTY_MAX;
            pwm_cnt    <= '0;
            prescaler  <= '0;
            leds       <= '0;
            step_pulse <= 1'b0;
        end else begin
            mode_q     <= mode_q_nxt;
            dir        <= dir_nxt;
            mask       <= mask_nxt;
            duty       <= duty_nxt;
            pwm_cnt    <= pwm_cnt_nxt;
            prescaler  <= prescaler_nxt;
            leds       <= leds_nxt;
            step_pulse <= step_nxt;
        end
    end

    always_comb begin
        mode_q_nxt    = mode_q;
        dir_nxt       = dir;
        mask_nxt      = mask;
        duty_nxt      = duty;
        pwm_cnt_nxt   = pwm_cnt;
        prescaler_nxt = prescaler;
        step_nxt      = 1'b0;
        leds_nxt      = (enable && (pwm_cnt < duty_eff)) ? mask : '0;

        if (enable) pwm_cnt_nxt = pwm_cnt + PWM_BITS'(1);

        // A mode change re-initialises the pattern even while disabled and wins over a step.
        if (mode != mode_q) begin
            mode_q_nxt    = mode_t'(mode);
            prescaler_nxt = '0;
            dir_nxt       = DIR_UP;
            case (mode_t'(mode))
                MODE_ALT:     begin mask_nxt = ALT_INIT; duty_nxt = DUTY_MAX; end
                MODE_CHASE:   begin mask_nxt = ONE_HOT;  duty_nxt = DUTY_MAX; end
                MODE_BOUNCE:  begin mask_nxt = ONE_HOT;  duty_nxt = DUTY_MAX; end
                MODE_BREATHE: begin mask_nxt = '1;       duty_nxt = '0;       end
            endcase
        end else if (enable) begin
            if (prescaler == PRE_LAST) begin
                prescaler_nxt = '0;
                step_nxt      = 1'b1;
                case (mode_q)
                    MODE_ALT:   mask_nxt = ~mask;
                    MODE_CHASE: mask_nxt = (mask << 1) | (mask >> (NUM_LEDS - 1));
                    MODE_BOUNCE: begin
                        // Turning at an end moves straight off it, so end LEDs light for one step.
                        if (NUM_LEDS > 1) begin
                            if (dir == DIR_UP) begin
                                if (mask[NUM_LEDS-1]) begin
                                    mask_nxt = mask >> 1;
                                    dir_nxt  = DIR_DOWN;
                                end else begin
                                    mask_nxt = mask << 1;
                                end
                            end else begin
                                if (mask[0]) begin
                                    mask_nxt = mask << 1;
                                    dir_nxt  = DIR_UP;
                                end else begin
                                    mask_nxt = mask >> 1;
                                end
                            end
                        end
                    end
                    MODE_BREATHE: begin
                        if (dir == DIR_UP) begin
                            if (duty == DUTY_MAX) begin
                                duty_nxt = DUTY_MAX - PWM_BITS'(1);
                                dir_nxt  = DIR_DOWN;
                            end else begin
                                duty_nxt = duty + PWM_BITS'(1);
                            end
                        end else begin
                            if (duty == '0) begin
                                duty_nxt = PWM_BITS'(1);
                                dir_nxt  = DIR_UP;
                            end else begin
                                duty_nxt = duty - PWM_BITS'(1);
                            end
                        end
                    end
                endcase
            end else begin
                prescaler_nxt = prescaler + PRE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_pwm.sv
// Directed bench for led_pattern_pwm: 4 LEDs, 3-bit PWM, one pattern step every 4 clocks.
module tb_led_pattern_pwm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] leds;
    logic       step_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int tb_pwm  = 0;
    int last_pwm = 0;
    int hi_cnt  = 0;
    int pulse_cnt = 0;
    logic [3:0] exp_q[$];
    logic [3:0] prev_mask;
    logic [3:0] next_mask;
    int breathe_seq[$];

    led_pattern_pwm #(
        .CLK_FREQ(1000),
        .NUM_LEDS(4),
        .PWM_BITS(3),
        .STEP_MS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .leds      (leds),
        .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    // Reference PWM phase: counts enabled cycles since reset, modulo 8.
    always @(posedge clk) begin
        if (!rst_n) tb_pwm <= 0;
        else if (enable) tb_pwm <= (tb_pwm + 1) % 8;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        int pre;
        pre = tb_pwm;
        @(posedge clk);
        #1;
        last_pwm = pre;
        if (leds != 4'b0) hi_cnt++;
        if (step_pulse) pulse_cnt++;
    endtask

    function automatic int eff(input int d);
`ifdef LED_GAMMA_EN
        return (d * d) >> 3;
`else
        return d;
`endif
    endfunction

    function automatic logic [3:0] exp_leds(input logic [3:0] m, input int d);
        return (last_pwm < eff(d)) ? m : 4'b0;
    endfunction

    task automatic observe(input string tag, input logic [3:0] m, input int d, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check({tag, " leds"}, leds, exp_leds(m, d));
            check({tag, " no_step"}, step_pulse, 1'b0);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] m, input int d);
        tick();
        check({tag, " step_pulse"}, step_pulse, 1'b1);
        check({tag, " step leds"}, leds, exp_leds(m, d));
    endtask

    task automatic mode_switch(input string tag, input logic [1:0] new_mode,
                               input logic [3:0] old_m, input int old_d);
        mode = new_mode;
        tick();
        check({tag, " switch no_step"}, step_pulse, 1'b0);
        check({tag, " switch leds"}, leds, exp_leds(old_m, old_d));
    endtask

    initial begin
        // Reset state
        enable = 1'b1;
        mode   = 2'd0;
        rst_n  = 1'b0;
        repeat (3) tick();
        check("reset leds", leds, 4'b0);
        check("reset step", step_pulse, 1'b0);

        // ALT: first step on the 4th edge after release
        rst_n  = 1'b1;
        hi_cnt = 0;
        observe("alt", 4'b0101, 7, 3);
        step("alt", 4'b0101, 7);
        observe("alt", 4'b1010, 7, 3);
        step("alt", 4'b1010, 7);
        check("alt window high cycles", hi_cnt, eff(7));

        // CHASE
        mode_switch("chase", 2'd1, 4'b0101, 7);
        observe("chase", 4'b0001, 7, 3);
        exp_q = {4'b0010, 4'b0100, 4'b1000, 4'b0001};
        prev_mask = 4'b0001;
        while (exp_q.size() > 0) begin
            next_mask = exp_q.pop_front();
            step("chase", prev_mask, 7);
            observe("chase", next_mask, 7, 3);
            prev_mask = next_mask;
        end

        // BOUNCE
        mode_switch("bounce", 2'd2, prev_mask, 7);
        observe("bounce", 4'b0001, 7, 3);
        exp_q = {4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        prev_mask = 4'b0001;
        while (exp_q.size() > 0) begin
            next_mask = exp_q.pop_front();
            step("bounce", prev_mask, 7);
            observe("bounce", next_mask, 7, 3);
            prev_mask = next_mask;
        end

        // Hold with enable=0 in CHASE at mask 0100, prescaler held at 1
        mode_switch("hold", 2'd1, prev_mask, 7);
        observe("hold", 4'b0001, 7, 3);
        step("hold", 4'b0001, 7);
        observe("hold", 4'b0010, 7, 3);
        step("hold", 4'b0010, 7);
        observe("hold", 4'b0100, 7, 1);
        enable    = 1'b0;
        hi_cnt    = 0;
        pulse_cnt = 0;
        repeat (10) tick();
        check("hold dark cycles", hi_cnt, 0);
        check("hold step pulses", pulse_cnt, 0);
        enable = 1'b1;
        observe("resume", 4'b0100, 7, 2);
        step("resume", 4'b0100, 7);
        observe("resume", 4'b1000, 7, 3);

        // BREATHE: switch lands where a step was due, so no pulse on that edge
        mode_switch("breathe", 2'd3, 4'b1000, 7);
        breathe_seq = {0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4};
        foreach (breathe_seq[k]) begin
            observe("breathe", 4'b1111, breathe_seq[k], 3);
            step("breathe", 4'b1111, breathe_seq[k]);
        end

        // BREATHE at duty 5 -> CHASE, switch on the edge a step was due
        observe("b2c", 4'b1111, 5, 3);
        mode_switch("b2c", 2'd1, 4'b1111, 5);
        observe("b2c", 4'b0001, 7, 3);
        step("b2c", 4'b0001, 7);
        observe("b2c", 4'b0010, 7, 3);

        // Reset mid-operation restores ALT timing from scratch
        rst_n = 1'b0;
        tick();
        check("reset2 leds", leds, 4'b0);
        check("reset2 step", step_pulse, 1'b0);
        tick();
        mode  = 2'd0;
        rst_n = 1'b1;
        observe("reset2", 4'b0101, 7, 3);
        step("reset2", 4'b0101, 7);
        observe("reset2", 4'b1010, 7, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_pwm.md
Name: led_pattern_pwm

Overview:
Parametrised multi-channel LED pattern generator with PWM brightness control, sitting directly on the board LED pins. It generalises the fixed alternating blinker to N LEDs, configurable PWM resolution and step period, and four run-time selectable patterns: alternate, chase, bounce and breathe. It also adds an enable/hold and a step strobe for other logic to sync to.

Parameters:
CLK_FREQ, 25_000_000, clk frequency in Hz
NUM_LEDS, 8, number of LED outputs (>=1)
PWM_BITS, 8, PWM counter/duty width
STEP_MS, 250, pattern step period in ms; STEP_CYCLES = CLK_FREQ/1000*STEP_MS, must be >=1

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
enable  in  1  1 = run; 0 = hold state, LEDs dark
mode  in  2  0 ALT, 1 CHASE, 2 BOUNCE, 3 BREATHE
leds  out  NUM_LEDS  registered PWM-gated LED drive
step_pulse  out  1  registered 1-cycle strobe on each pattern advance

Behaviour:
- Reset (rst_n=0 at posedge):
  - leds=0, step_pulse=0, prescaler=0, pwm_cnt=0.
  - mode_q=0 (ALT), mask=...0101 (bit0=1), duty=2^PWM_BITS-1, dir=up.
- pwm_cnt: PWM_BITS wide, +1 per enabled cycle, wraps 2^PWM_BITS-1 -> 0.
- LED output, registered, 1-cycle latency from state:
  - leds[i] <= enable & mask[i] & (pwm_cnt < duty_eff).
  - duty_eff=0 -> always off; duty_eff=max -> on 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
- Prescaler:
  - Counts 0..STEP_CYCLES-1.
  - On the edge where it equals STEP_CYCLES-1: reset to 0, advance the pattern on the same edge, set step_pulse=1 for exactly that one cycle.
- Mode change (mode != mode_q, sampled each clk, takes priority over a step):
  - mode_q<=mode, prescaler<=0, dir<=up, no step_pulse.
  - Re-init: ALT mask=...0101, duty=max; CHASE/BOUNCE mask=one-hot bit0, duty=max; BREATHE mask=all ones, duty=0.
- Pattern advance per mode:
  - ALT: mask <= ~mask.
  - CHASE: rotate left; bit NUM_LEDS-1 wraps to bit0.
  - BOUNCE: one-hot shifts left while dir=up. On reaching bit NUM_LEDS-1 dir flips, then it shifts right to bit0 and flips again. End LEDs are lit for one step only (no repeat). NUM_LEDS=1: mask stays 1.
  - BREATHE: duty +1 while up. At max, dir flips and the next step is max-1. At 0 it flips to up. Triangle period is 2*(2^PWM_BITS-1) steps.
- enable=0:
  - leds forced 0 on next edge.
  - prescaler, pwm_cnt, mask, duty, dir held; step_pulse=0.
  - A mode change while disabled is still applied.
  - On re-enable, counting resumes from the held values.
- Reset mid-operation: restores full reset state on that edge, regardless of enable/mode.

Optional Feature:
LED_GAMMA_EN
- Defined: duty_eff = (duty*duty) >> PWM_BITS, using a full 2*PWM_BITS product, giving perceptual dimming in all modes. Max duty 255 with 8 bits -> duty_eff 254.
- Undefined: duty_eff = duty (linear).
- Latency unchanged either way.

Test Plan:
(Bench parameters: CLK_FREQ=1000, STEP_MS=4 -> STEP_CYCLES=4, NUM_LEDS=4, PWM_BITS=3.)
1. Reset then mode=0, enable=1 -> leds=0 during reset. Afterwards, leds=0101 for 7 of 8 cycles in each PWM window. First step_pulse on the 4th edge after release, then mask=1010.
2. mode=1 -> successive step masks 0001, 0010, 0100, 1000, 0001; step_pulse every 4 cycles.
3. mode=2 -> 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
4. mode=3 -> duty 0, 1, ..., 7, 6, ..., 0, 1. At duty=3, all 4 LEDs high exactly 3 cycles per 8-cycle window. With LED_GAMMA_EN, duty=7 gives 6 high cycles.
5. CHASE at mask 0100, enable=0 for 10 cycles -> leds=0000 from next edge, no step_pulse. After re-enable, mask 0100 resumes and the prescaler continues from its held count.
6. BREATHE at duty 5, switch mode to 1 -> next edge mask=0001, duty=7, no step_pulse. First step_pulse 4 cycles later with mask=0010.
